ipm_frame_loader: RTL and testbench

// - Input processing stage feeding the router bus IPM port. Buffers an incoming sample stream and, once per

---
 rtl/ipm_frame_loader_pkg.sv | 18 +
 rtl/ipm_frame_loader_sync_fifo.sv | 55 +++++
 rtl/ipm_frame_loader.sv | 192 +++++++++++++++++++
 tb/tb_ipm_frame_loader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipm_frame_loader_pkg.sv
// ipm_frame_loader_pkg
//   Shared widths for the router IPM path and the frame loader state encoding.
//   GLB_* values mirror the global data/address/offset widths of the router bus.
package ipm_frame_loader_pkg;

   localparam int GLB_D_LEN     = 16;
   localparam int GLB_DA_AWIDTH = 10;
   localparam int GLB_OFS_WIDTH = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WRITE = 3'd2,
      ST_DROP  = 3'd3,
      ST_DONE  = 3'd4
   } ipm_state_e;

endpackage

// File: rtl/ipm_frame_loader_sync_fifo.sv
// ipm_sync_fifo
//   Small synchronous show-ahead FIFO: dout always presents the oldest entry.
//   A push while full is accepted only when a pop happens in the same cycle.
// Ports
//   clk, rst      clock, synchronous active-high reset (flushes pointers)
//   push, din     write request and data
//   pop           read request (ignored when empty)
//   dout          oldest entry
//   full, empty   occupancy flags
module ipm_sync_fifo
   import ipm_frame_loader_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = GLB_D_LEN + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // extra pointer MSB distinguishes full from empty
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ipm_frame_loader.sv
// ipm_frame_loader
//   Buffers a sample stream and writes one FRAME_LEN-word frame per request into
//   activation PRAM through the router IPM port. Short frames are zero padded,
//   long frames are truncated and their tail discarded; both flag frame_err.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last   input sample stream
//   frame_base               PRAM base, captured when a frame starts
//   ipm_request/ipm_enable   router request / grant
//   ipm_wen/ipm_din/ipm_offset/ipm_base   registered write port
//   ipm_finish, frame_err    one-cycle status pulses
//   busy                     loader not idle
//
// state    | meaning
// ST_IDLE  | waiting for the first buffered sample of a frame
// ST_REQ   | requesting the router, waiting for grant
// ST_WRITE | writing words (from FIFO, or zeros in pad mode)
// ST_DROP  | discarding the tail of an over-long frame up to s_last
// ST_DONE  | one-cycle ipm_finish, request released
module ipm_frame_loader
   import ipm_frame_loader_pkg::*;
#(
   parameter int D_LEN      = GLB_D_LEN,
   parameter int DA_AWIDTH  = GLB_DA_AWIDTH,
   parameter int OFS_WIDTH  = GLB_OFS_WIDTH,
   parameter int FRAME_LEN  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [D_LEN-1:0]     s_data,
   input  logic                 s_last,
   input  logic [DA_AWIDTH-1:0] frame_base,
   output logic                 ipm_request,
   input  logic                 ipm_enable,
   output logic                 ipm_wen,
   output logic [D_LEN-1:0]     ipm_din,
   output logic [DA_AWIDTH-1:0] ipm_base,
   output logic [OFS_WIDTH-1:0] ipm_offset,
   output logic                 ipm_finish,
   output logic                 frame_err,
   output logic                 busy
);

   localparam logic [OFS_WIDTH-1:0] LAST_OFS = OFS_WIDTH'(FRAME_LEN - 1);
   localparam int LCW = $clog2(FIFO_DEPTH + 1);

   ipm_state_e           state;
   ipm_state_e           state_nxt;
   logic [OFS_WIDTH-1:0] cnt;
   logic                 pad;
   logic [LCW-1:0]       last_cnt;

   logic                 wen_q;
   logic [D_LEN-1:0]     din_q;
   logic [OFS_WIDTH-1:0] ofs_q;
   logic [DA_AWIDTH-1:0] base_q;
   logic                 err_q;

   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [D_LEN:0]       fifo_dout;
   logic                 f_last;
   logic [D_LEN-1:0]     f_data;

   logic                 do_write;
   logic                 err_nxt;
   logic                 pad_set;
   logic                 start_frame;
   logic                 lc_inc;
   logic                 lc_dec;

   assign f_last = fifo_dout[D_LEN];
   assign f_data = fifo_dout[D_LEN-1:0];

   // While dropping, stop accepting once the terminating s_last word is buffered,
   // so the next frame's samples wait upstream until the drop completes.
   assign s_ready   = !rst && !fifo_full && !((state == ST_DROP) && (last_cnt != '0));
   assign fifo_push = s_valid && s_ready;

   ipm_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (D_LEN + 1)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   ({s_last, s_data}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_nxt   = state;
      fifo_pop    = 1'b0;
      do_write    = 1'b0;
      err_nxt     = 1'b0;
      pad_set     = 1'b0;
      start_frame = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_nxt   = ST_REQ;
               start_frame = 1'b1;
            end
         end
         ST_REQ: begin
            if (ipm_enable) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (ipm_enable && (pad || !fifo_empty)) begin
               do_write = 1'b1;
               fifo_pop = !pad;
               if (cnt == LAST_OFS) begin
                  if (pad || f_last) begin
                     state_nxt = ST_DONE;
                  end else begin
                     state_nxt = ST_DROP;
                     err_nxt   = 1'b1;
                  end
               end else if (!pad && f_last) begin
                  err_nxt = 1'b1;
                  pad_set = 1'b1;
               end
            end
         end
         ST_DROP: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (f_last) state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign lc_inc = fifo_push && s_last;
   assign lc_dec = fifo_pop && !fifo_empty && f_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         pad      <= 1'b0;
         last_cnt <= '0;
         wen_q    <= 1'b0;
         din_q    <= '0;
         ofs_q    <= '0;
         base_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start_frame) begin
            base_q <= frame_base;
            cnt    <= '0;
            pad    <= 1'b0;
         end
         // counter saturates at the last offset; the frame ends there anyway
         if (do_write && (cnt != LAST_OFS)) cnt <= cnt + OFS_WIDTH'(1);
         if (pad_set) pad <= 1'b1;
         if (lc_inc && !lc_dec)      last_cnt <= last_cnt + LCW'(1);
         else if (lc_dec && !lc_inc) last_cnt <= last_cnt - LCW'(1);
         wen_q <= do_write;
         if (do_write) begin
            din_q <= pad ? '0 : f_data;
            ofs_q <= cnt;
         end
         err_q <= err_nxt;
      end
   end

   assign ipm_request = (state == ST_REQ) || (state == ST_WRITE);
   assign ipm_wen     = wen_q;
   assign ipm_din     = din_q;
   assign ipm_offset  = ofs_q;
   assign ipm_base    = base_q;
   assign ipm_finish  = (state == ST_DONE);
   assign frame_err   = err_q;
   assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_ipm_frame_loader.sv
module tb_ipm_frame_loader;
   import ipm_frame_loader_pkg::*;

   localparam int FRAME_LEN = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic        s_last = 1'b0;
   logic [9:0]  frame_base = '0;
   logic        ipm_request;
   logic        ipm_enable = 1'b0;
   logic        ipm_wen;
   logic [15:0] ipm_din;
   logic [9:0]  ipm_base;
   logic [9:0]  ipm_offset;
   logic        ipm_finish;
   logic        frame_err;
   logic        busy;

   always #5 clk = ~clk;

   ipm_frame_loader #(
      .FRAME_LEN  (FRAME_LEN),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .frame_base  (frame_base),
      .ipm_request (ipm_request),
      .ipm_enable  (ipm_enable),
      .ipm_wen     (ipm_wen),
      .ipm_din     (ipm_din),
      .ipm_base    (ipm_base),
      .ipm_offset  (ipm_offset),
      .ipm_finish  (ipm_finish),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   typedef struct {
      logic [9:0]  base;
      logic [9:0]  ofs;
      logic [15:0] din;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  n_cmp = 0;
   int  n_mis = 0;
   int  fin_cnt = 0;
   int  err_cnt = 0;
   int  wen_seen = 0;
   int  gap_wen = 0;
   int  stall_cnt = 0;
   bit  gap_active = 0;
   bit  abort = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard side: every write the DUT makes must match the queue head
   always @(negedge clk) begin
      if (!rst) begin
         if (ipm_wen) begin
            wen_seen++;
            if (gap_active) gap_wen++;
            if (exp_q.size() == 0) begin
               check_val("unexpected_wen", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check_val("ipm_offset", 32'(ipm_offset), 32'(mon_e.ofs));
               check_val("ipm_din", 32'(ipm_din), 32'(mon_e.din));
               check_val("ipm_base", 32'(ipm_base), 32'(mon_e.base));
            end
         end
         if (ipm_finish) fin_cnt++;
         if (frame_err) err_cnt++;
      end
   end

   task automatic push_exp(input logic [9:0] base, input int n, input int first);
      wr_t e;
      for (int i = 0; i < FRAME_LEN; i++) begin
         e.base = base;
         e.ofs  = 10'(i);
         e.din  = (i < n) ? 16'(first + i) : 16'd0;
         exp_q.push_back(e);
      end
   endtask

   task automatic send_frame(input logic [9:0] base, input int n, input int first);
      int t;
      frame_base = base;
      for (int i = 0; i < n; i++) begin
         if (abort) break;
         s_valid = 1'b1;
         s_data  = 16'(first + i);
         s_last  = (i == n - 1);
         t = 0;
         while (!s_ready && !abort) begin
            stall_cnt++;
            @(negedge clk);
            t++;
            if (t > 3000) begin
               check_val("s_ready_timeout", 32'd0, 32'd1);
               abort = 1;
            end
         end
         if (abort) break;
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (2) @(negedge clk);
      check_val("rst_s_ready", 32'(s_ready), 32'd0);
      check_val("rst_request", 32'(ipm_request), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_wen", 32'(ipm_wen), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_s_ready", 32'(s_ready), 32'd1);
      check_val("post_rst_offset", 32'(ipm_offset), 32'd0);
      check_val("post_rst_base", 32'(ipm_base), 32'd0);
      exp_q.delete();
      fin_cnt  = 0;
      err_cnt  = 0;
      wen_seen = 0;
      abort    = 0;
   endtask

   task automatic wait_done(input string tag, input int fin_exp, input int err_exp);
      int t;
      t = 0;
      while (fin_cnt < fin_exp && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) check_val({tag, "_finish_timeout"}, 32'd0, 32'd1);
      repeat (5) @(negedge clk);
      check_val({tag, "_finish_cnt"}, 32'(fin_cnt), 32'(fin_exp));
      check_val({tag, "_err_cnt"}, 32'(err_cnt), 32'(err_exp));
      check_val({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
      check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t;
      @(negedge clk);

      // T1: nominal frame, grant after 2 cycles
      ipm_enable = 1'b0;
      do_reset();
      push_exp(10'h000, 64, 1);
      fork
         send_frame(10'h000, 64, 1);
         begin
            repeat (2) @(negedge clk);
            ipm_enable = 1'b1;
         end
      join
      wait_done("t1", 1, 0);
      check_val("t1_wen_cnt", 32'(wen_seen), 32'd64);

      // T2: grant withdrawn for offsets 10..14
      do_reset();
      ipm_enable = 1'b1;
      gap_wen = 0;
      push_exp(10'h040, 64, 1);
      fork
         send_frame(10'h040, 64, 1);
         begin
            t = 0;
            while (!(ipm_wen && ipm_offset == 10'd9) && t < 2000) begin
               @(negedge clk);
               t++;
            end
            check_val("t2_gap_trigger", 32'(t < 2000), 32'd1);
            ipm_enable = 1'b0;
            @(negedge clk);
            gap_active = 1;
            repeat (4) @(negedge clk);
            check_val("t2_request_held", 32'(ipm_request), 32'd1);
            ipm_enable = 1'b1;
            gap_active = 0;
         end
      join
      wait_done("t2", 1, 0);
      check_val("t2_gap_wen", 32'(gap_wen), 32'd0);

      // T3: short frame, zero padded
      do_reset();
      ipm_enable = 1'b1;
      push_exp(10'h080, 40, 1);
      send_frame(10'h080, 40, 1);
      wait_done("t3", 1, 1);

      // T4: long frame, tail dropped, following frame starts at offset 0
      do_reset();
      push_exp(10'h0C0, 70, 1);
      push_exp(10'h020, 64, 201);
      send_frame(10'h0C0, 70, 1);
      send_frame(10'h020, 64, 201);
      wait_done("t4", 2, 1);
      check_val("t4_wen_cnt", 32'(wen_seen), 32'd128);

      // T5: back-to-back frames with a late grant so the FIFO fills
      do_reset();
      ipm_enable = 1'b0;
      stall_cnt = 0;
      push_exp(10'h000, 64, 1);
      push_exp(10'h100, 64, 101);
      fork
         begin
            send_frame(10'h000, 64, 1);
            send_frame(10'h100, 64, 101);
         end
         begin
            repeat (20) @(negedge clk);
            ipm_enable = 1'b1;
         end
      join
      wait_done("t5", 2, 0);
      check_val("t5_s_ready_stalled", 32'(stall_cnt > 0), 32'd1);

      // T6: reset mid-frame at offset 30, then a clean frame
      do_reset();
      ipm_enable = 1'b1;
      push_exp(10'h140, 64, 1);
      fork
         send_frame(10'h140, 64, 1);
         begin
            t = 0;
            while (!(ipm_wen && ipm_offset == 10'd30) && t < 2000) begin
               @(negedge clk);
               t++;
            end
            check_val("t6_rst_trigger", 32'(t < 2000), 32'd1);
            abort = 1;
            rst   = 1'b1;
            @(negedge clk);
            check_val("t6_request", 32'(ipm_request), 32'd0);
            check_val("t6_wen", 32'(ipm_wen), 32'd0);
            check_val("t6_finish", 32'(ipm_finish), 32'd0);
            check_val("t6_err", 32'(frame_err), 32'd0);
            check_val("t6_busy", 32'(busy), 32'd0);
            check_val("t6_offset", 32'(ipm_offset), 32'd0);
            check_val("t6_base", 32'(ipm_base), 32'd0);
            check_val("t6_s_ready_in_rst", 32'(s_ready), 32'd0);
            @(negedge clk);
            rst = 1'b0;
         end
      join
      @(negedge clk);
      check_val("t6_s_ready_after", 32'(s_ready), 32'd1);
      check_val("t6_busy_after", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check_val("t6_no_finish", 32'(fin_cnt), 32'd0);
      check_val("t6_no_err", 32'(err_cnt), 32'd0);
      check_val("t6_idle_wen", 32'(ipm_wen), 32'd0);
      exp_q.delete();
      abort = 0;
      push_exp(10'h180, 64, 501);
      send_frame(10'h180, 64, 501);
      wait_done("t6b", 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
